// File: rtl/ar_4kb_splitter.sv
// AR-channel 4KB boundary splitter: an INCR read that crosses a 4KB page goes downstream as two bursts,
// and the RLAST of the first part is hidden from the master. Optional macro AR_4KB_SPLIT_CNT_EN adds split_cnt_o.
module ar_4kb_splitter #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned LEN_WIDTH   = 8,
  parameter int unsigned SIZE_WIDTH  = 3,
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned OUTST_DEPTH = 4
) (
  input  logic                  ACLK_i,
  input  logic                  ARESETn_i,
  // upstream AR
  input  logic [ID_WIDTH-1:0]   ARID_i,
  input  logic [ADDR_WIDTH-1:0] ARADDR_i,
  input  logic [LEN_WIDTH-1:0]  ARLEN_i,
  input  logic [SIZE_WIDTH-1:0] ARSIZE_i,
  input  logic [1:0]            ARBURST_i,
  input  logic                  ARVALID_i,
  output logic                  ARREADY_o,
  // downstream AR
  output logic [ID_WIDTH-1:0]   ARID_o,
  output logic [ADDR_WIDTH-1:0] ARADDR_o,
  output logic [LEN_WIDTH-1:0]  ARLEN_o,
  output logic [SIZE_WIDTH-1:0] ARSIZE_o,
  output logic [1:0]            ARBURST_o,
  output logic                  ARVALID_o,
  input  logic                  ARREADY_i,
  // downstream R
  input  logic [ID_WIDTH-1:0]   RID_i,
  input  logic [DATA_WIDTH-1:0] RDATA_i,
  input  logic [1:0]            RRESP_i,
  input  logic                  RLAST_i,
  input  logic                  RVALID_i,
  output logic                  RREADY_o,
  // upstream R
  output logic [ID_WIDTH-1:0]   RID_o,
  output logic [DATA_WIDTH-1:0] RDATA_o,
  output logic [1:0]            RRESP_o,
  output logic                  RLAST_o,
  output logic                  RVALID_o,
  input  logic                  RREADY_i
`ifdef AR_4KB_SPLIT_CNT_EN
  ,
  output logic [15:0]           split_cnt_o
`endif
);

  // Beat arithmetic must hold both 4096 and ARLEN+1
  localparam int unsigned CW   = ((LEN_WIDTH + 1) > 13) ? (LEN_WIDTH + 1) : 13;
  localparam int unsigned PW   = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
  localparam int unsigned CNTW = PW + 1;
  localparam int unsigned HW   = ADDR_WIDTH - 12;
  localparam logic [1:0]  BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND_FIRST  = 2'd1,
    SEND_SECOND = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                  arready_q, arready_d;
  logic                  cross_q;
  logic [ADDR_WIDTH-1:0] addr2_q;
  logic [LEN_WIDTH-1:0]  len2_q;

  logic [11:0]           a_low;
  logic [CW-1:0]         beats_to_bnd;
  logic [CW-1:0]         len_p1;
  logic                  cross_c;
  logic [LEN_WIDTH-1:0]  len1_c;
  logic [LEN_WIDTH-1:0]  len2_c;
  logic [ADDR_WIDTH-1:0] addr2_c;

  logic [OUTST_DEPTH-1:0] flag_q;
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]        count_q, count_d;
  logic                   first_done_q;
  logic                   fifo_empty;
  logic                   head_cross;

  logic push;
  logic pop;
  logic load_second;
  logic r_last_hs;
  logic suppress;

  // Split computation on the upstream request, using the size-aligned start address
  always_comb begin
    a_low        = ARADDR_i[11:0] & (12'hFFF << ARSIZE_i);
    beats_to_bnd = CW'((13'h1000 - {1'b0, a_low}) >> ARSIZE_i);
    len_p1       = CW'(ARLEN_i) + CW'(1);
    cross_c      = (ARBURST_i == BURST_INCR) && (len_p1 > beats_to_bnd);
    len1_c       = LEN_WIDTH'(beats_to_bnd - CW'(1));
    len2_c       = LEN_WIDTH'(CW'(ARLEN_i) - beats_to_bnd);
    addr2_c      = {ARADDR_i[ADDR_WIDTH-1:12] + HW'(1), 12'h000};
  end

  // Read path is a pass-through except for the hidden first-part RLAST
  assign fifo_empty = (count_q == '0);
  assign head_cross = flag_q[rd_ptr_q];
  assign r_last_hs  = RVALID_i && RREADY_i && RLAST_i;
  assign suppress   = !fifo_empty && head_cross && !first_done_q;
  assign pop        = r_last_hs && !fifo_empty && !suppress;

  assign RVALID_o = RVALID_i;
  assign RREADY_o = RREADY_i;
  assign RID_o    = RID_i;
  assign RDATA_o  = RDATA_i;
  assign RRESP_o  = RRESP_i;
  assign RLAST_o  = RLAST_i && !suppress;

  assign ARREADY_o = arready_q;

  // Next-state and strobes
  always_comb begin
    state_d     = state_q;
    push        = 1'b0;
    load_second = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ARVALID_i && arready_q) begin
          push    = 1'b1;
          state_d = SEND_FIRST;
        end
      end
      SEND_FIRST: begin
        if (ARREADY_i) begin
          load_second = cross_q;
          state_d     = cross_q ? SEND_SECOND : IDLE;
        end
      end
      SEND_SECOND: begin
        if (ARREADY_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    count_d   = count_q + CNTW'(push) - CNTW'(pop);
    arready_d = (state_d == IDLE) && (count_d < CNTW'(OUTST_DEPTH));
  end

  // State and registered AR outputs
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      state_q   <= IDLE;
      arready_q <= 1'b0;
      ARVALID_o <= 1'b0;
      ARID_o    <= '0;
      ARADDR_o  <= '0;
      ARLEN_o   <= '0;
      ARSIZE_o  <= '0;
      ARBURST_o <= '0;
      cross_q   <= 1'b0;
      addr2_q   <= '0;
      len2_q    <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      ARVALID_o <= (state_d != IDLE);
      if (push) begin
        ARID_o    <= ARID_i;
        ARADDR_o  <= ARADDR_i;
        ARLEN_o   <= cross_c ? len1_c : ARLEN_i;
        ARSIZE_o  <= ARSIZE_i;
        ARBURST_o <= ARBURST_i;
        cross_q   <= cross_c;
        addr2_q   <= addr2_c;
        len2_q    <= len2_c;
      end else if (load_second) begin
        ARADDR_o <= addr2_q;
        ARLEN_o  <= len2_q;
      end
    end
  end

  // In-order split-flag FIFO plus the "first part already ended" marker for the head entry
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      flag_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      first_done_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) begin
        flag_q[wr_ptr_q] <= cross_c;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q     <= rd_ptr_q + PW'(1);
        first_done_q <= 1'b0;
      end else if (r_last_hs && suppress) begin
        first_done_q <= 1'b1;
      end
    end
  end

`ifdef AR_4KB_SPLIT_CNT_EN
  // Saturating count of requests that were split
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      split_cnt_o <= '0;
    end else if (load_second && (split_cnt_o != 16'hFFFF)) begin
      split_cnt_o <= split_cnt_o + 16'd1;
    end
  end
`endif

endmodule
